// File: rtl/i2c_master_write_byte.sv
// rtl/i2c_master_write_byte.sv - I2C master byte transmitter (MSB-first, 9th-clock ACK sample)
// Optional slave clock stretching in Q2 is enabled with `define I2C_CLOCK_STRETCH_EN.
module i2c_master_write_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic go,
    input  logic data,
    output logic load,
    output logic finish,
    output logic error,
    output logic scl,
    output logic sda,
    input  logic scl_in,
    input  logic sda_in
);

    localparam int QW = $clog2(CLK_DIV) + 1;
    localparam logic [QW-1:0] QTR_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [QW-1:0] qtr;
    logic [QW-1:0] qtr_nx;
    logic [1:0]    phase;
    logic [1:0]    phase_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nx;
    logic          sda_nx;
    logic          error_nx;

    logic          active;
    logic          stall;
    logic          q0_first;
    logic          qtr_end;
    logic          bit_end;

    assign active   = (state == BIT) || (state == ACK);
    assign q0_first = (phase == 2'd0) && (qtr == '0);

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the high half of the bit.
    assign stall = active && (phase == 2'd2) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign qtr_end = (qtr == QTR_LAST) && !stall;
    assign bit_end = qtr_end && (phase == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            qtr     <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            sda     <= 1'b1;
            error   <= 1'b0;
        end else begin
            state   <= state_nx;
            qtr     <= qtr_nx;
            phase   <= phase_nx;
            bit_cnt <= bit_cnt_nx;
            sda     <= sda_nx;
            error   <= error_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        qtr_nx     = qtr;
        phase_nx   = phase;
        bit_cnt_nx = bit_cnt;
        sda_nx     = sda;
        error_nx   = error;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nx   = BIT;
                    qtr_nx     = '0;
                    phase_nx   = '0;
                    bit_cnt_nx = 3'd7;
                    error_nx   = 1'b0;
                end
            end
            BIT, ACK: begin
                if (!stall) begin
                    if (qtr == QTR_LAST) begin
                        qtr_nx   = '0;
                        phase_nx = phase + 2'd1;
                    end else begin
                        qtr_nx = qtr + QW'(1);
                    end
                end
                if (state == BIT) begin
                    if (q0_first) begin
                        sda_nx = data;
                    end
                    if (bit_end) begin
                        if (bit_cnt == 3'd0) begin
                            // Release SDA so the slave owns it for the whole ACK clock.
                            state_nx = ACK;
                            sda_nx   = 1'b1;
                        end else begin
                            bit_cnt_nx = bit_cnt - 3'd1;
                        end
                    end
                end else begin
                    if ((phase == 2'd2) && qtr_end) begin
                        error_nx = sda_in;
                    end
                    if (bit_end) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        load   = 1'b0;
        finish = 1'b0;
        scl    = 1'b0;
        case (state)
            BIT: begin
                scl  = phase[1];
                load = q0_first;
            end
            ACK: begin
                scl = phase[1];
            end
            DONE: begin
                finish = 1'b1;
            end
            default: begin
                scl = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// tb/tb_i2c_master_write_byte.sv - self-checking bench for i2c_master_write_byte
module tb_i2c_master_write_byte;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic go1, data1, sda_in1, scl_in1;
    logic load1, finish1, error1, scl1, sda1;
    logic go2, data2, sda_in2, scl_in2, hold2;
    logic load2, finish2, error2, scl2, sda2;

    assign scl_in1 = scl1;
    assign scl_in2 = scl2 & ~hold2;

    i2c_master_write_byte #(.CLK_DIV(1)) dut1 (
        .clock(clk), .reset(rst), .go(go1), .data(data1), .load(load1),
        .finish(finish1), .error(error1), .scl(scl1), .sda(sda1),
        .scl_in(scl_in1), .sda_in(sda_in1)
    );

    i2c_master_write_byte #(.CLK_DIV(2)) dut2 (
        .clock(clk), .reset(rst), .go(go2), .data(data2), .load(load2),
        .finish(finish2), .error(error2), .scl(scl2), .sda(sda2),
        .scl_in(scl_in2), .sda_in(sda_in2)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] bytes_a [8];
    logic       acks_a  [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(input int p);
        logic [7:0] b;
        b = bytes_a[p / 8];
        return b[7 - (p % 8)];
    endfunction

    // Run n bytes on the CLK_DIV=1 instance; go is dropped from cycle go_drop on.
    task automatic run_seq(input int n, input int go_drop, input string name);
        int         d = 1;
        int         span;
        int         budget;
        int         ptr = 0;
        int         r = 0;
        logic       prev_scl;
        logic [7:0] sh = 8'h00;
        int         loads_q [$];
        int         fin_q [$];
        logic       err_q [$];
        logic [7:0] got_q [$];
        logic       slot_q [$];
        span   = 36 * d + 2;
        budget = n * span + 45;
        @(posedge clk); #1;
        go1      = 1'b1;
        data1    = bit_of(0);
        sda_in1  = acks_a[0];
        prev_scl = scl1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            go1     = (c < go_drop);
            sda_in1 = acks_a[(fin_q.size() < n) ? fin_q.size() : n - 1];
            data1   = (ptr < 8 * n) ? bit_of(ptr) : 1'b0;
            if (load1) begin
                if (ptr % 8 == 0) check({name, " error_cleared"}, error1, 1'b0);
                loads_q.push_back(c);
                ptr++;
            end
            if (scl1 && !prev_scl) begin
                if (r < 8) begin
                    sh = {sh[6:0], sda1};
                    r++;
                end else begin
                    got_q.push_back(sh);
                    slot_q.push_back(sda1);
                    r = 0;
                end
            end
            prev_scl = scl1;
            if (finish1) begin
                fin_q.push_back(c);
                err_q.push_back(error1);
            end
        end
        go1 = 1'b0;
        check({name, " load_count"}, loads_q.size(), 8 * n);
        for (int i = 0; i < loads_q.size() && i < 8 * n; i++)
            check({name, " load_cycle"}, loads_q[i], (i / 8) * span + 1 + 4 * d * (i % 8));
        check({name, " finish_count"}, fin_q.size(), n);
        for (int b = 0; b < fin_q.size() && b < n; b++) begin
            check({name, " finish_cycle"}, fin_q[b], b * span + 36 * d + 1);
            check({name, " error"}, err_q[b], acks_a[b]);
        end
        check({name, " byte_count"}, got_q.size(), n);
        for (int b = 0; b < got_q.size() && b < n; b++) begin
            check({name, " sda_byte"}, got_q[b], bytes_a[b]);
            check({name, " ack_released"}, slot_q[b], 1'b1);
        end
    endtask

    initial begin
        int fin_cyc;
        int nloads;
        int nfin;
        int p2;
        logic [7:0] b2;
        rst = 1'b1;
        go1 = 0; data1 = 0; sda_in1 = 1;
        go2 = 0; data2 = 0; sda_in2 = 0; hold2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst scl", scl1, 1'b0);
        check("rst sda", sda1, 1'b1);
        check("rst load", load1, 1'b0);
        check("rst finish", finish1, 1'b0);
        check("rst error", error1, 1'b0);
        check("rst scl2", scl2, 1'b0);
        rst = 1'b0;

        // T1: 0xA5 acked
        bytes_a[0] = 8'hA5; acks_a[0] = 1'b0;
        run_seq(1, 10, "T1");

        // T2: 0xA5 nacked; error must be held while idle
        acks_a[0] = 1'b1;
        run_seq(1, 10, "T2");
        repeat (3) @(posedge clk);
        #1;
        check("T2 error_held", error1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("T2 error_reset", error1, 1'b0);
        rst = 1'b0;

        // T3: back-to-back with go held high
        bytes_a[0] = 8'h13; bytes_a[1] = 8'h57; bytes_a[2] = 8'h9B; bytes_a[3] = 8'hDF;
        acks_a[0] = 0; acks_a[1] = 1; acks_a[2] = 0; acks_a[3] = 0;
        run_seq(4, 3 * 38 + 5, "T3");

        // T4: reset at cycle 15 mid-byte
        bytes_a[0] = 8'h3C; acks_a[0] = 1'b0;
        @(posedge clk); #1;
        go1 = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            go1 = 1'b0;
            data1 = c[0];
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("T4 scl", scl1, 1'b0);
        check("T4 sda", sda1, 1'b1);
        check("T4 load", load1, 1'b0);
        check("T4 finish", finish1, 1'b0);
        check("T4 error", error1, 1'b0);
        rst = 1'b0;
        nfin = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (finish1 || load1) nfin++;
        end
        check("T4 quiet_after_reset", nfin, 0);
        run_seq(1, 2, "T4clean");

        // T5: go dropped at cycle 3, exactly one byte
        bytes_a[0] = 8'h6E; acks_a[0] = 1'b0;
        run_seq(1, 3, "T5");

        // Randomized back-to-back bytes
        for (int i = 0; i < 3; i++) begin
            bytes_a[i] = 8'($urandom);
            acks_a[i]  = 1'($urandom_range(0, 1));
        end
        run_seq(3, 2 * 38 + 2, "RND");

        // T6: CLK_DIV=2, slave holds SCL low 5 cycles in Q2 of bit 4
        b2 = 8'hC6;
        p2 = 0;
        fin_cyc = -1;
        nloads = 0;
        @(posedge clk); #1;
        go2 = 1'b1;
        data2 = b2[7];
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            go2   = (c < 2);
            hold2 = (c >= 37) && (c <= 41);
            data2 = (p2 < 8) ? b2[7 - p2] : 1'b0;
            if (load2) begin
                nloads++;
                p2++;
            end
`ifdef I2C_CLOCK_STRETCH_EN
            if (hold2) check("T6 scl_held", scl2, 1'b1);
`endif
            if (finish2) begin
                fin_cyc = c;
                check("T6 error", error2, 1'b0);
            end
        end
        hold2 = 1'b0;
        check("T6 loads", nloads, 8);
`ifdef I2C_CLOCK_STRETCH_EN
        check("T6 finish_cycle", fin_cyc, 36 * 2 + 1 + 5);
`else
        check("T6 finish_cycle", fin_cyc, 36 * 2 + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
